wheel_step_gen: RTL and testbench

- Upstream stage of the LED chaser; derives angular timing for the unicycle lights from a once-per-revolution hall sensor.
- Measures wheel revolution period and divides it into STEPS equal angular slots.
- Emits a one-cycle `step` strobe plus the current slot index, which the chaser uses instead of its fixed free-running divider.
- Detects a stopped wheel and reports it so the chaser can fall back to its idle pattern.

---
 rtl/wheel_step_gen.sv | 184 ++++++++++++++++++
 tb/tb_wheel_step_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/wheel_step_gen.sv
// Hall-sensor revolution timing: measures the wheel period and emits STEPS angular slot strobes.
// Define HALL_DEBOUNCE_EN to insert the DEBOUNCE-cycle hall input filter after the synchronizer.
module wheel_step_gen #(
    parameter int STEPS    = 8,
    parameter int CNT_W    = 32,
    parameter int DEBOUNCE = 50000,
    parameter int TIMEOUT  = 100000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     hall_in,
    output logic                     step,
    output logic [$clog2(STEPS)-1:0] slot,
    output logic                     rev,
    output logic                     stalled,
    output logic [CNT_W-1:0]         period
);
    localparam int                SLOT_W    = $clog2(STEPS);
    localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(STEPS - 1);

    if (STEPS < 2 || STEPS > 256 || (STEPS & (STEPS - 1)) != 0) begin : g_bad_steps
        $error("wheel_step_gen: STEPS must be a power of two in 2..256");
    end
    if (DEBOUNCE < 1 || TIMEOUT < 1) begin : g_bad_timing
        $error("wheel_step_gen: DEBOUNCE and TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        STALL,
        SYNC,
        RUN
    } state_t;

    state_t            state;
    state_t            state_n;
    logic              hall_s1;
    logic              hall_s2;
    logic              hall_filt;
    logic              hall_filt_d;
    logic              index;
    logic              timeout_hit;
    logic [CNT_W-1:0]  pcnt;
    logic [CNT_W-1:0]  timer;
    logic [CNT_W-1:0]  timer_n;
    logic [CNT_W-1:0]  shifted;
    logic [CNT_W-1:0]  interval;
    logic [CNT_W-1:0]  period_n;
    logic [SLOT_W-1:0] slot_n;
    logic              step_n;
    logic              rev_n;

    // Synchronizer resets to the idle (magnet absent) level so reset release never fakes an index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hall_s1 <= 1'b1;
            hall_s2 <= 1'b1;
        end else begin
            hall_s1 <= hall_in;
            hall_s2 <= hall_s1;
        end
    end

`ifdef HALL_DEBOUNCE_EN
    localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hall_filt <= 1'b1;
            db_cnt    <= '0;
        end else if (hall_s2 == hall_filt) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DEBOUNCE - 1)) begin
            hall_filt <= hall_s2;
            db_cnt    <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end
`else
    assign hall_filt = hall_s2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hall_filt_d <= 1'b1;
        end else begin
            hall_filt_d <= hall_filt;
        end
    end

    assign index = hall_filt_d & ~hall_filt;

    // pcnt saturates so a stopped wheel never wraps into a bogus short period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (index) begin
            pcnt <= '0;
        end else if (pcnt < TIMEOUT_C) begin
            pcnt <= pcnt + 1'b1;
        end
    end

    assign timeout_hit = (pcnt >= TIMEOUT_C - 1'b1);
    assign shifted     = period >> SLOT_W;
    assign interval    = (shifted == '0) ? CNT_W'(1) : shifted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= STALL;
            step    <= 1'b0;
            rev     <= 1'b0;
            slot    <= '0;
            timer   <= '0;
            period  <= '0;
            stalled <= 1'b1;
        end else begin
            state   <= state_n;
            step    <= step_n;
            rev     <= rev_n;
            slot    <= slot_n;
            timer   <= timer_n;
            period  <= period_n;
            stalled <= (state_n != RUN);
        end
    end

    // Index has priority over both timer expiry and timeout; the last slot absorbs the remainder.
    always_comb begin
        state_n  = state;
        step_n   = 1'b0;
        rev_n    = index;
        slot_n   = slot;
        timer_n  = timer;
        period_n = period;
        case (state)
            STALL: begin
                slot_n  = '0;
                timer_n = '0;
                if (index) begin
                    state_n = SYNC;
                end
            end
            SYNC: begin
                if (index) begin
                    state_n  = RUN;
                    period_n = pcnt + 1'b1;
                    step_n   = 1'b1;
                    slot_n   = '0;
                    timer_n  = '0;
                end else if (timeout_hit) begin
                    state_n = STALL;
                end
            end
            RUN: begin
                if (index) begin
                    period_n = pcnt + 1'b1;
                    step_n   = 1'b1;
                    slot_n   = '0;
                    timer_n  = '0;
                end else if (timeout_hit) begin
                    state_n = STALL;
                    slot_n  = '0;
                    timer_n = '0;
                end else if (slot != LAST_SLOT) begin
                    if (timer == interval - 1'b1) begin
                        step_n  = 1'b1;
                        timer_n = '0;
                        slot_n  = slot + 1'b1;
                    end else begin
                        timer_n = timer + 1'b1;
                    end
                end
            end
            default: begin
                state_n = STALL;
            end
        endcase
    end

endmodule

// File: tb/tb_wheel_step_gen.sv
// Scoreboard bench for wheel_step_gen: directed hall pulses queue hand-computed step/rev events.
// Works with or without HALL_DEBOUNCE_EN; only the hall-to-rev latency and glitch outcome differ.
module tb_wheel_step_gen;
    localparam int STEPS    = 8;
    localparam int CNT_W    = 32;
    localparam int DEBOUNCE = 4;
    localparam int TIMEOUT  = 1000;
`ifdef HALL_DEBOUNCE_EN
    localparam int LAT        = 3 + DEBOUNCE;
    localparam bit GLITCH_REV = 1'b0;
`else
    localparam int LAT        = 3;
    localparam bit GLITCH_REV = 1'b1;
`endif

    typedef struct {
        int cyc;
        bit rev;
        bit step;
        int slot;
        bit stalled;
        int period;
    } ev_t;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     hall_in = 1'b1;
    logic                     step;
    logic [$clog2(STEPS)-1:0] slot;
    logic                     rev;
    logic                     stalled;
    logic [CNT_W-1:0]         period;

    int  cyc = 0;
    int  vectors = 0;
    int  errors = 0;
    int  ev_seen = 0;
    ev_t exp_q[$];

    wheel_step_gen #(
        .STEPS(STEPS),
        .CNT_W(CNT_W),
        .DEBOUNCE(DEBOUNCE),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .hall_in(hall_in),
        .step(step),
        .slot(slot),
        .rev(rev),
        .stalled(stalled),
        .period(period)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_ev(input int c, input bit r, input bit s, input int sl, input bit st, input int p);
        ev_t e;
        e.cyc = c; e.rev = r; e.step = s; e.slot = sl; e.stalled = st; e.period = p;
        exp_q.push_back(e);
    endtask

    task automatic push_rev_run(input int c, input int iv, input int last_i, input int p);
        push_ev(c, 1'b1, 1'b1, 0, 1'b0, p);
        for (int i = 1; i <= last_i; i++) push_ev(c + i * iv, 1'b0, 1'b1, i, 1'b0, p);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic applyStimulus(input int at_cyc, input int low_cycles);
        wait_cyc(at_cyc);
        hall_in = 1'b0;
        repeat (low_cycles) @(negedge clk);
        hall_in = 1'b1;
    endtask

    task automatic checkOutput(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every step/rev strobe must match the oldest queued expectation exactly.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (step || rev) begin
                ev_seen++;
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_event: got cyc=%0d rev=%0b step=%0b slot=%0d, required no event",
                             cyc, rev, step, slot);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc != e.cyc || rev != e.rev || step != e.step || int'(slot) != e.slot ||
                        stalled != e.stalled || period != CNT_W'(e.period)) begin
                        errors++;
                        $display("[TB] FAIL event: got cyc=%0d rev=%0b step=%0b slot=%0d stalled=%0b period=%0d, required cyc=%0d rev=%0b step=%0b slot=%0d stalled=%0b period=%0d",
                                 cyc, rev, step, slot, stalled, period,
                                 e.cyc, e.rev, e.step, e.slot, e.stalled, e.period);
                    end
                end
            end
        end
    end

    initial begin
        int a, b, c, d, e, f, g, h, base;
        repeat (3) @(negedge clk);
        checkOutput("reset_step", int'(step), 0);
        checkOutput("reset_rev", int'(rev), 0);
        checkOutput("reset_slot", int'(slot), 0);
        checkOutput("reset_stalled", int'(stalled), 1);
        checkOutput("reset_period", int'(period), 0);
        rst_n = 1'b1;

        base = ev_seen;
        wait_cyc(cyc + 2000);
        checkOutput("idle_events", ev_seen - base, 0);
        checkOutput("idle_stalled", int'(stalled), 1);

        $display("[TB] steady 400-cycle revolutions");
        a = cyc + 10;
        push_ev(a + LAT, 1'b1, 1'b0, 0, 1'b1, 0);
        applyStimulus(a, 10);
        b = a + 400;
        push_rev_run(b + LAT, 50, 7, 400);
        applyStimulus(b, 10);
        c = b + 400;
        push_rev_run(c + LAT, 50, 7, 400);
        applyStimulus(c, 10);
        wait_cyc(c + LAT + 1);
        checkOutput("run_period", int'(period), 400);
        checkOutput("run_stalled", int'(stalled), 0);

        $display("[TB] 403-cycle revolutions, last slot holds");
        d = c + 403;
        push_rev_run(d + LAT, 50, 7, 403);
        applyStimulus(d, 10);
        wait_cyc(d + LAT + 390);
        checkOutput("slot_hold_403", int'(slot), 7);

        $display("[TB] index coinciding with timer expiry");
        e = d + 403;
        push_rev_run(e + LAT, 50, 5, 403);
        applyStimulus(e, 10);
        f = e + 300;
        push_rev_run(f + LAT, 37, 7, 300);
        applyStimulus(f, 10);

        $display("[TB] wheel stops, timeout to stall");
        wait_cyc(f + LAT + 999);
        checkOutput("pre_timeout_stalled", int'(stalled), 0);
        checkOutput("pre_timeout_slot", int'(slot), 7);
        wait_cyc(f + LAT + 1000);
        checkOutput("timeout_stalled", int'(stalled), 1);
        checkOutput("timeout_slot", int'(slot), 0);
        checkOutput("timeout_period", int'(period), 300);
        base = ev_seen;
        wait_cyc(cyc + 500);
        checkOutput("stall_events", ev_seen - base, 0);

        $display("[TB] 3-cycle hall glitch");
        g = cyc + 5;
        if (GLITCH_REV) push_ev(g + LAT, 1'b1, 1'b0, 0, 1'b1, 300);
        applyStimulus(g, 3);
        wait_cyc(g + 1300);
        checkOutput("post_glitch_stalled", int'(stalled), 1);

        $display("[TB] asynchronous reset mid-revolution");
        g = cyc + 10;
        push_ev(g + LAT, 1'b1, 1'b0, 0, 1'b1, 300);
        applyStimulus(g, 10);
        h = g + 400;
        push_rev_run(h + LAT, 50, 3, 400);
        applyStimulus(h, 10);
        wait_cyc(h + LAT + 170);
        checkOutput("pre_reset_slot", int'(slot), 3);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_slot", int'(slot), 0);
        checkOutput("async_reset_stalled", int'(stalled), 1);
        checkOutput("async_reset_period", int'(period), 0);
        checkOutput("async_reset_step", int'(step), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(cyc + 300);
        checkOutput("post_reset_stalled", int'(stalled), 1);
        checkOutput("pending_events", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
